// File: rtl/axi4l_sram_if.sv
// rtl/axi4l_sram_if.sv - AXI4-lite bus bundle between the picorv32_axi master and the SRAM slave
interface axi4l_sram_if;
    logic        mem_axi_awvalid;
    logic        mem_axi_awready;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid;
    logic        mem_axi_wready;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid;
    logic        mem_axi_bready;
    logic        mem_axi_arvalid;
    logic        mem_axi_arready;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid;
    logic        mem_axi_rready;
    logic [31:0] mem_axi_rdata;

    modport master (
        output mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        output mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        output mem_axi_bready,
        output mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        output mem_axi_rready,
        input  mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        input  mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );

    modport slave (
        input  mem_axi_awvalid, mem_axi_awaddr, mem_axi_awprot,
        input  mem_axi_wvalid, mem_axi_wdata, mem_axi_wstrb,
        input  mem_axi_bready,
        input  mem_axi_arvalid, mem_axi_araddr, mem_axi_arprot,
        input  mem_axi_rready,
        output mem_axi_awready, mem_axi_wready, mem_axi_bvalid,
        output mem_axi_arready, mem_axi_rvalid, mem_axi_rdata
    );
endinterface

// File: rtl/axi4l_sram_slave.sv
// rtl/axi4l_sram_slave.sv - AXI4-lite SRAM slave with console and test-pass MMIO registers
module axi4l_sram_slave #(
    parameter int unsigned MEM_WORDS    = 32768,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_MAGIC   = 32'd123456789
) (
    input  logic              clk,
    input  logic              resetn,
    axi4l_sram_if.slave       mem_axi,
    output logic              console_valid,
    output logic [7:0]        console_data,
    output logic              tests_passed,
    output logic              bus_error,
    output logic [31:0]       bus_error_addr
);
    localparam int unsigned IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    logic [31:0] memory [0:MEM_WORDS-1];

    logic        aw_full;
    logic        w_full;
    logic        ar_full;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] raddr;
    logic        bvalid;
    logic        rvalid;
    logic [31:0] rdata;

    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        do_commit;
    logic        do_read;
    logic [31:0] wa_word;
    logic [31:0] ra_word;
    logic        w_in_mem;
    logic        w_is_con;
    logic        w_is_pass;
    logic        w_err;
    logic        r_in_mem;
    logic        r_is_mmio;
    logic        r_err;
    logic        unused_prot;

    assign mem_axi.mem_axi_awready = !aw_full;
    assign mem_axi.mem_axi_wready  = !w_full;
    assign mem_axi.mem_axi_arready = !ar_full && !rvalid;
    assign mem_axi.mem_axi_bvalid  = bvalid;
    assign mem_axi.mem_axi_rvalid  = rvalid;
    assign mem_axi.mem_axi_rdata   = rdata;

    assign aw_hs = mem_axi.mem_axi_awvalid && !aw_full;
    assign w_hs  = mem_axi.mem_axi_wvalid && !w_full;
    assign ar_hs = mem_axi.mem_axi_arvalid && !ar_full && !rvalid;

    // ar_full can only be set while rvalid is low, so a pending read never overlaps a held response
    assign do_commit = aw_full && w_full && !bvalid;
    assign do_read   = ar_full;

    assign wa_word   = {waddr[31:2], 2'b00};
    assign ra_word   = {raddr[31:2], 2'b00};
    assign w_in_mem  = wa_word < MEM_BYTES;
    assign w_is_con  = wa_word == CONSOLE_ADDR;
    assign w_is_pass = wa_word == PASS_ADDR;
    assign w_err     = !w_in_mem && !w_is_con && !w_is_pass;
    assign r_in_mem  = ra_word < MEM_BYTES;
    assign r_is_mmio = (ra_word == CONSOLE_ADDR) || (ra_word == PASS_ADDR);
    assign r_err     = !r_in_mem && !r_is_mmio;

    assign unused_prot = ^{mem_axi.mem_axi_awprot, mem_axi.mem_axi_arprot};

    // SRAM contents survive reset; a commit is blocked while resetn is low
    always_ff @(posedge clk) begin
        if (resetn && do_commit && w_in_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    memory[waddr[IDX_W+1:2]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_full        <= 1'b0;
            w_full         <= 1'b0;
            ar_full        <= 1'b0;
            waddr          <= 32'd0;
            wdata          <= 32'd0;
            wstrb          <= 4'd0;
            raddr          <= 32'd0;
            bvalid         <= 1'b0;
            rvalid         <= 1'b0;
            rdata          <= 32'd0;
            console_valid  <= 1'b0;
            console_data   <= 8'd0;
            tests_passed   <= 1'b0;
            bus_error      <= 1'b0;
            bus_error_addr <= 32'd0;
        end else begin
            console_valid <= 1'b0;

            if (bvalid && mem_axi.mem_axi_bready) begin
                bvalid <= 1'b0;
            end

            if (do_commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bvalid  <= 1'b1;
                if (w_is_con && wstrb[0]) begin
                    console_valid <= 1'b1;
                    console_data  <= wdata[7:0];
                end
                if (w_is_pass && (wdata == PASS_MAGIC)) begin
                    tests_passed <= 1'b1;
                end
            end

            if (aw_hs) begin
                waddr   <= mem_axi.mem_axi_awaddr;
                aw_full <= 1'b1;
            end
            if (w_hs) begin
                wdata  <= mem_axi.mem_axi_wdata;
                wstrb  <= mem_axi.mem_axi_wstrb;
                w_full <= 1'b1;
            end

            if (rvalid && mem_axi.mem_axi_rready) begin
                rvalid <= 1'b0;
            end

            if (do_read) begin
                ar_full <= 1'b0;
                rvalid  <= 1'b1;
                if (r_in_mem) begin
                    rdata <= memory[raddr[IDX_W+1:2]];
                end else if (r_is_mmio) begin
                    rdata <= 32'd0;
                end else begin
                    rdata <= 32'hDEAD_BEEF;
                end
            end

            if (ar_hs) begin
                raddr   <= mem_axi.mem_axi_araddr;
                ar_full <= 1'b1;
            end

            // Only the first offending address is kept; a read wins a same-edge tie
            if ((do_read && r_err) || (do_commit && w_err)) begin
                bus_error <= 1'b1;
                if (!bus_error) begin
                    bus_error_addr <= (do_read && r_err) ? raddr : waddr;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi4l_sram_slave.sv
// tb/tb_axi4l_sram_slave.sv - scoreboard bench for axi4l_sram_slave with a word-level memory model
module tb_axi4l_sram_slave;
    localparam int unsigned MEM_WORDS    = 32768;
    localparam logic [31:0] MEM_BYTES    = 32'(MEM_WORDS * 4);
    localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
    localparam logic [31:0] PASS_ADDR    = 32'h2000_0000;
    localparam logic [31:0] PASS_MAGIC   = 32'd123456789;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        console_valid;
    logic [7:0]  console_data;
    logic        tests_passed;
    logic        bus_error;
    logic [31:0] bus_error_addr;

    always #5 clk = ~clk;

    axi4l_sram_if bus ();

    axi4l_sram_slave #(
        .MEM_WORDS(MEM_WORDS),
        .CONSOLE_ADDR(CONSOLE_ADDR),
        .PASS_ADDR(PASS_ADDR),
        .PASS_MAGIC(PASS_MAGIC)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .mem_axi(bus),
        .console_valid(console_valid),
        .console_data(console_data),
        .tests_passed(tests_passed),
        .bus_error(bus_error),
        .bus_error_addr(bus_error_addr)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_model [int];
    logic [31:0] exp_r [$];
    logic [7:0]  exp_con [$];
    int          exp_b = 0;
    int          r_seen = 0;
    int          b_seen = 0;
    int          con_seen = 0;
    bit          model_pass = 0;
    bit          model_err = 0;
    logic [31:0] model_err_addr = 32'd0;

    bit bp_mode = 0;
    bit rready_cmd = 1;
    bit bready_cmd = 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] a;
        logic [31:0] w;
        a = addr & 32'hFFFF_FFFC;
        if (a < MEM_BYTES) begin
            w = mem_model[int'(a >> 2)];
            for (int b = 0; b < 4; b++)
                if (strb[b]) w[8*b +: 8] = data[8*b +: 8];
            mem_model[int'(a >> 2)] = w;
        end else if (a == CONSOLE_ADDR) begin
            if (strb[0]) exp_con.push_back(data[7:0]);
        end else if (a == PASS_ADDR) begin
            if (data == PASS_MAGIC) model_pass = 1;
        end else begin
            if (!model_err) model_err_addr = addr;
            model_err = 1;
        end
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] addr);
        logic [31:0] a;
        a = addr & 32'hFFFF_FFFC;
        if (a < MEM_BYTES) return mem_model[int'(a >> 2)];
        if (a == CONSOLE_ADDR || a == PASS_ADDR) return 32'd0;
        if (!model_err) model_err_addr = addr;
        model_err = 1;
        return 32'hDEAD_BEEF;
    endfunction

    // Response monitor: pops expectations whenever the DUT completes a handshake
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.mem_axi_rvalid && bus.mem_axi_rready) begin
                chk("r_expected", 32'(exp_r.size() != 0), 32'd1);
                if (exp_r.size() != 0) chk("rdata", bus.mem_axi_rdata, exp_r.pop_front());
                r_seen++;
            end
            if (bus.mem_axi_bvalid && bus.mem_axi_bready) begin
                chk("b_expected", 32'(exp_b > 0), 32'd1);
                if (exp_b > 0) exp_b--;
                b_seen++;
            end
            if (console_valid) begin
                chk("console_expected", 32'(exp_con.size() != 0), 32'd1);
                if (exp_con.size() != 0) chk("console_data", 32'(console_data), 32'(exp_con.pop_front()));
                con_seen++;
            end
        end
    end

    initial begin
        bus.mem_axi_rready = 1'b1;
        bus.mem_axi_bready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.mem_axi_rready = ($urandom_range(0, 3) != 0);
                bus.mem_axi_bready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.mem_axi_rready = rready_cmd;
                bus.mem_axi_bready = bready_cmd;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_b(input int target);
        int c = 0;
        while (b_seen < target && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bresp_done", 32'(b_seen >= target), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int w_lead, input bit wait_resp);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs;
        bit w_hs;
        int cyc = 0;
        mdl_write(addr, data, strb);
        exp_b++;
        bus.mem_axi_awaddr  = addr;
        bus.mem_axi_awprot  = 3'($urandom);
        bus.mem_axi_wdata   = data;
        bus.mem_axi_wstrb   = strb;
        bus.mem_axi_wvalid  = 1'b1;
        bus.mem_axi_awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            @(negedge clk);
            aw_hs = bus.mem_axi_awvalid && bus.mem_axi_awready;
            w_hs  = bus.mem_axi_wvalid && bus.mem_axi_wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) begin bus.mem_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin bus.mem_axi_wvalid  = 1'b0; w_done  = 1; end
            if (!aw_done && cyc >= w_lead) bus.mem_axi_awvalid = 1'b1;
        end
        chk("write_handshake", 32'(aw_done && w_done), 32'd1);
        if (wait_resp) wait_b(b_seen + exp_b);
    endtask

    task automatic do_read(input logic [31:0] addr, input bit check_lat);
        bit hs = 0;
        int cyc = 0;
        int target;
        exp_r.push_back(mdl_read(addr));
        target = r_seen + 1;
        bus.mem_axi_araddr  = addr;
        bus.mem_axi_arprot  = 3'($urandom);
        bus.mem_axi_arvalid = 1'b1;
        while (!hs && cyc < 50) begin
            @(negedge clk);
            hs = bus.mem_axi_arvalid && bus.mem_axi_arready;
            @(posedge clk); #1;
            cyc++;
        end
        bus.mem_axi_arvalid = 1'b0;
        chk("ar_handshake", 32'(hs), 32'd1);
        if (check_lat) begin
            @(negedge clk);
            chk("rvalid_after_ar_edge", 32'(bus.mem_axi_rvalid), 32'd0);
            @(negedge clk);
            chk("rvalid_after_ar_edge_plus1", 32'(bus.mem_axi_rvalid), 32'd1);
        end
        cyc = 0;
        while (r_seen < target && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("rresp_done", 32'(r_seen >= target), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        logic [31:0] orig;
        int k;
        int con0;
        int tgt;

        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_awaddr  = 32'd0;
        bus.mem_axi_awprot  = 3'd0;
        bus.mem_axi_wvalid  = 1'b0;
        bus.mem_axi_wdata   = 32'd0;
        bus.mem_axi_wstrb   = 4'd0;
        bus.mem_axi_arvalid = 1'b0;
        bus.mem_axi_araddr  = 32'd0;
        bus.mem_axi_arprot  = 3'd0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        @(negedge clk);
        chk("reset_awready", 32'(bus.mem_axi_awready), 32'd1);
        chk("reset_wready", 32'(bus.mem_axi_wready), 32'd1);
        chk("reset_arready", 32'(bus.mem_axi_arready), 32'd1);
        chk("reset_bvalid", 32'(bus.mem_axi_bvalid), 32'd0);
        chk("reset_rvalid", 32'(bus.mem_axi_rvalid), 32'd0);
        chk("reset_console_valid", 32'(console_valid), 32'd0);
        chk("reset_tests_passed", 32'(tests_passed), 32'd0);
        chk("reset_bus_error", 32'(bus_error), 32'd0);
        chk("reset_bus_error_addr", bus_error_addr, 32'd0);

        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            if (i == 32'h40) v = 32'd0;
            mem_model[i] = v;
            dut.memory[i] = v;
        end
        @(posedge clk); #1;

        // Partial-strobe write then timed read back
        do_write(32'h0000_0100, 32'hA5A5_1234, 4'b0101, 0, 1);
        do_read(32'h0000_0100, 1);

        // W leads AW by 3 cycles, bready held low: second write must wait for bvalid to clear
        bready_cmd = 0;
        @(posedge clk); #1;
        do_write(32'h0000_0200, $urandom, 4'hF, 3, 0);
        @(negedge clk);
        chk("bvalid_before_commit", 32'(bus.mem_axi_bvalid), 32'd0);
        @(negedge clk);
        chk("bvalid_after_commit", 32'(bus.mem_axi_bvalid), 32'd1);
        chk("awready_recovers", 32'(bus.mem_axi_awready), 32'd1);
        chk("wready_recovers", 32'(bus.mem_axi_wready), 32'd1);
        @(posedge clk); #1;
        do_write(32'h0000_0204, $urandom, 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bvalid_held", 32'(bus.mem_axi_bvalid), 32'd1);
            chk("no_second_commit", 32'(bus.mem_axi_awready), 32'd0);
        end
        bready_cmd = 1;
        wait_b(b_seen + exp_b);
        do_read(32'h0000_0200, 0);
        do_read(32'h0000_0204, 0);

        // Console byte and pass register
        con0 = con_seen;
        do_write(CONSOLE_ADDR, 32'h0000_0041, 4'b0001, 0, 1);
        repeat (3) @(negedge clk);
        chk("console_pulse_count", 32'(con_seen - con0), 32'd1);
        @(posedge clk); #1;
        do_write(PASS_ADDR, 32'd5, 4'hF, 0, 1);
        @(negedge clk);
        chk("tests_passed_after_5", 32'(tests_passed), 32'(model_pass));
        @(posedge clk); #1;
        do_write(PASS_ADDR, PASS_MAGIC, 4'hF, 0, 1);
        @(negedge clk);
        chk("tests_passed_after_magic", 32'(tests_passed), 32'(model_pass));
        @(posedge clk); #1;

        // Randomized traffic with back-pressure on both response channels
        bp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, 15);
            a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            if (k < 7)       do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), 1);
            else if (k < 13) do_read(a, 0);
            else if (k == 13) do_write(CONSOLE_ADDR | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)), 0, 1);
            else             do_read((k == 14) ? CONSOLE_ADDR : PASS_ADDR, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Illegal accesses: first address is sticky
        do_read(32'h0003_0000, 0);
        @(negedge clk);
        chk("bus_error_after_read", 32'(bus_error), 32'(model_err));
        chk("bus_error_addr_read", bus_error_addr, model_err_addr);
        @(posedge clk); #1;
        do_write(32'h3000_0000, $urandom, 4'hF, 0, 1);
        @(negedge clk);
        chk("bus_error_addr_sticky", bus_error_addr, model_err_addr);
        chk("bus_error_still_set", 32'(bus_error), 32'd1);
        @(posedge clk); #1;

        // Reset with a write fully latched but not yet committed
        orig = mem_model[32'h300 >> 2];
        bus.mem_axi_awaddr = 32'h0000_0300;
        bus.mem_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_axi_awvalid = 1'b0;
        bus.mem_axi_wdata = ~orig;
        bus.mem_axi_wstrb = 4'hF;
        bus.mem_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        bus.mem_axi_wvalid = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        model_pass = 0;
        model_err = 0;
        model_err_addr = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bvalid_after_midreset", 32'(bus.mem_axi_bvalid), 32'd0);
        end
        chk("bus_error_cleared", 32'(bus_error), 32'd0);
        chk("tests_passed_cleared", 32'(tests_passed), 32'd0);
        @(posedge clk); #1;
        do_read(32'h0000_0300, 0);

        repeat (3) @(posedge clk);
        #1;
        tgt = 0;
        chk("r_queue_drained", 32'(exp_r.size()), 32'(tgt));
        chk("console_queue_drained", 32'(exp_con.size()), 32'(tgt));
        chk("b_outstanding_drained", 32'(exp_b), 32'(tgt));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
